// File: rtl/data_cache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache for the MEM stage.
// Read misses fetch a whole line; every store goes to memory; saturating access/hit counters.

module dcr_line #(
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WORDS = 4,
  parameter int TAG_W      = 12,
  parameter int OFF_W      = 2
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  fill_i,
  input  logic [TAG_W-1:0]                      fill_tag_i,
  input  logic [LINE_WORDS-1:0][WORD_SIZE-1:0]  fill_data_i,
  input  logic                                  wr_i,
  input  logic [OFF_W-1:0]                      wr_off_i,
  input  logic [WORD_SIZE-1:0]                  wr_data_i,
  output logic                                  vld_o,
  output logic [TAG_W-1:0]                      tag_o,
  output logic [LINE_WORDS-1:0][WORD_SIZE-1:0]  data_o
);
  logic                                 vld_q;
  logic [TAG_W-1:0]                     tag_q;
  logic [LINE_WORDS-1:0][WORD_SIZE-1:0] data_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q  <= 1'b0;
      tag_q  <= '0;
      data_q <= '0;
    end else if (fill_i) begin
      vld_q  <= 1'b1;
      tag_q  <= fill_tag_i;
      data_q <= fill_data_i;
    end else if (wr_i) begin
      data_q[wr_off_i] <= wr_data_i;
    end
  end

  assign vld_o  = vld_q;
  assign tag_o  = tag_q;
  assign data_o = data_q;
endmodule

module data_cache_responder #(
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            cpu_read,
  input  logic                            cpu_write,
  input  logic [WORD_SIZE-1:0]            cpu_addr,
  input  logic [WORD_SIZE-1:0]            cpu_wdata,
  output logic [WORD_SIZE-1:0]            cpu_rdata,
  output logic                            cpu_ready,
  output logic                            d_cache_hit,
  output logic                            mem_read,
  output logic                            mem_write,
  output logic [WORD_SIZE-1:0]            mem_addr,
  output logic [WORD_SIZE-1:0]            mem_wdata,
  input  logic [LINE_WORDS*WORD_SIZE-1:0] mem_rdata,
  input  logic                            mem_ack,
  output logic [WORD_SIZE-1:0]            access_count,
  output logic [WORD_SIZE-1:0]            hit_count
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = WORD_SIZE - OFF_W - IDX_W;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [OFF_W-1:0] off;
  } addr_t;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  state_t                                               state_q, state_d;
  logic                                                 retry_q, retry_d;
  logic [TAG_W-1:0]                                     fill_tag_q, fill_tag_d;
  logic [IDX_W-1:0]                                     fill_idx_q, fill_idx_d;
  logic [WORD_SIZE-1:0]                                 access_q, access_d;
  logic [WORD_SIZE-1:0]                                 hit_q, hit_d;

  addr_t                                                req_a;
  logic                                                 req, hit, count_en;
  logic                                                 fill_en, wr_en;
  logic [LINE_WORDS-1:0][WORD_SIZE-1:0]                 fill_line;
  logic [NUM_LINES-1:0]                                 line_vld;
  logic [NUM_LINES-1:0][TAG_W-1:0]                      line_tag;
  logic [NUM_LINES-1:0][LINE_WORDS-1:0][WORD_SIZE-1:0]  line_data;

  assign req_a     = addr_t'(cpu_addr);
  assign req       = cpu_read | cpu_write;
  assign hit       = req & line_vld[req_a.idx] & (line_tag[req_a.idx] == req_a.tag);
  assign fill_line = mem_rdata;

  assign d_cache_hit = hit;
  assign cpu_rdata   = line_data[req_a.idx][req_a.off];

  // The fill installs at the captured miss address, not whatever the CPU drives now.
  assign fill_en = (state_q == FILL) & mem_ack;
  assign wr_en   = (state_q == WRITE) & mem_ack & hit;

  for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
    dcr_line #(
      .WORD_SIZE (WORD_SIZE),
      .LINE_WORDS(LINE_WORDS),
      .TAG_W     (TAG_W),
      .OFF_W     (OFF_W)
    ) u_line (
      .clk        (clk),
      .reset_n    (reset_n),
      .fill_i     (fill_en && (fill_idx_q == IDX_W'(i))),
      .fill_tag_i (fill_tag_q),
      .fill_data_i(fill_line),
      .wr_i       (wr_en && (req_a.idx == IDX_W'(i))),
      .wr_off_i   (req_a.off),
      .wr_data_i  (cpu_wdata),
      .vld_o      (line_vld[i]),
      .tag_o      (line_tag[i]),
      .data_o     (line_data[i])
    );
  end

  always_comb begin
    state_d    = state_q;
    retry_d    = retry_q;
    fill_tag_d = fill_tag_q;
    fill_idx_d = fill_idx_q;
    cpu_ready  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    count_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // The retried read after a fill is the same access; clear the flag, count nothing.
        retry_d  = 1'b0;
        count_en = req & ~retry_q;
        if (cpu_write) begin
          state_d = WRITE;
        end else if (cpu_read) begin
          if (hit) begin
            cpu_ready = 1'b1;
          end else begin
            state_d    = FILL;
            fill_tag_d = req_a.tag;
            fill_idx_d = req_a.idx;
          end
        end
      end
      FILL: begin
        mem_read = 1'b1;
        mem_addr = {fill_tag_q, fill_idx_q, OFF_W'(0)};
        if (mem_ack) begin
          state_d = IDLE;
          retry_d = 1'b1;
        end
      end
      WRITE: begin
        mem_write = 1'b1;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        cpu_ready = mem_ack;
        if (mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    access_d = access_q;
    hit_d    = hit_q;
    if (count_en && (access_q != '1)) access_d = access_q + 1'b1;
    if (count_en && hit && (hit_q != '1)) hit_d = hit_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      retry_q    <= 1'b0;
      fill_tag_q <= '0;
      fill_idx_q <= '0;
      access_q   <= '0;
      hit_q      <= '0;
    end else begin
      state_q    <= state_d;
      retry_q    <= retry_d;
      fill_tag_q <= fill_tag_d;
      fill_idx_q <= fill_idx_d;
      access_q   <= access_d;
      hit_q      <= hit_d;
    end
  end

  assign access_count = access_q;
  assign hit_count    = hit_q;
endmodule
